uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_cfg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding, parity-mode encodings and the baud-divisor helpers.
package uart_pkg;

  // FSM state encoding, kept as plain constants for legacy tooling
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Parity-mode encodings on cfg_parity; 2'b11 is folded onto PAR_NONE
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Clock cycles per line bit; integer division, caller keeps it >= 2
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Requested data-bit count, with anything outside 5..max_w mapped to max_w
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input int         max_w);
    if ((int'(req) < 5) || (int'(req) > max_w)) begin
      return 4'(max_w);
    end
    return req;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses tick on the last cycle of every BAUD_DIV-cycle
// bit period while enabled; restart forces the count back to zero so a new
// frame always begins on a full-length bit.
module uart_baud_gen #(
  parameter int BAUD_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-BAUD_DIV counter, cleared on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DATA_W data bits, optional parity,
// one or two stop bits, LSB first, line idles high.
// Build option: define UART_TX_PARITY_EN to honour cfg_parity and build
// the PARITY state; without it cfg_parity is accepted but ignored.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_DIV = calc_baud_div(CLOCK_FREQ, BAUD_RATE);

  uart_state_t       state;
  logic              accept;
  logic              baud_en;
  logic              tick;
  logic [3:0]        nbits_in;
  logic [3:0]        nbits_q;
  logic [3:0]        bit_cnt;
  logic              stop2_q;
  logic              stop_cnt;
  logic              tx_q;
  logic              done_q;
  logic [DATA_W-1:0] data_masked;
  logic [DATA_W-1:0] shreg;

`ifdef UART_TX_PARITY_EN
  logic              par_en_in;
  logic              par_bit_in;
  logic              par_en_q;
  logic              par_bit_q;

  // Parity over the bits actually sent; odd mode is the inverse of even
  function automatic logic parity_of(input logic [DATA_W-1:0] d,
                                     input logic              odd);
    return odd ^ (^d);
  endfunction
`else
  logic              unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
`endif

  assign accept   = tx_valid && (state == ST_IDLE);
  assign baud_en  = (state != ST_IDLE);
  assign nbits_in = clamp_data_bits(cfg_data_bits, DATA_W);

  // Zero the payload bits above the configured width so they never reach
  // the line or the parity calculation
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < DATA_W; i++) begin
      data_masked[i] = tx_data[i] & (i < int'(nbits_in));
    end
  end

`ifdef UART_TX_PARITY_EN
  assign par_en_in  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
  assign par_bit_in = parity_of(data_masked, cfg_parity == PAR_ODD);
`endif

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (baud_en),
    .restart (accept),
    .tick    (tick)
  );

  // Frame sequencer: latches the configuration on accept, steps through the
  // frame on each bit-end tick and drives the registered line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      nbits_q  <= 4'(DATA_W);
      stop2_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_START;
            tx_q     <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            nbits_q  <= nbits_in;
            stop2_q  <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_in;
            par_bit_q <= par_bit_in;
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            tx_q    <= shreg[0];
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == (nbits_q - 4'd1)) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state <= ST_PARITY;
                tx_q  <= par_bit_q;
              end else begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end
`else
              state <= ST_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_q    <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            tx_q  <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // Payload shift register: loaded on accept, shifted right at the end of
  // each data bit so bit 1 always holds the next bit to send
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= data_masked;
    end else if ((state == ST_DATA) && tick) begin
      shreg <= shreg >> 1;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);
  assign tx_done  = done_q;

endmodule
